// File: rtl/alu_seq.sv
// alu_seq: registered valid/ready ALU with single-cycle logic ops and iterative multiply/divide
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             dz,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [3:0] OP_MUL = 4'b1010, OP_DIVU = 4'b1011, OP_REMU = 4'b1100;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, overflow_q, overflow_d, zero_q, zero_d, dz_q, dz_d;
  logic accept, is_multi, sc_carry, sc_ovf;
  logic [WIDTH:0] sum, diff, mul_sum, div_t;
  logic [WIDTH-1:0] sc_res, div_r, mc_res;
  logic [SHW-1:0] sh;
  logic [2*WIDTH-1:0] mul_next, div_next, step;
  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign is_multi  = (op == OP_MUL) | (op == OP_DIVU) | (op == OP_REMU);
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign dz        = dz_q;
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign sh   = b[SHW-1:0];
  always_comb begin
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    case (op)
      4'b0000: sc_res = a & b;
      4'b0001: sc_res = a | b;
      4'b0010: begin
        sc_res   = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
        sc_ovf   = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0011: sc_res = a << sh;
      4'b0100: sc_res = a ^ b;
      4'b0101: begin
        sc_res   = diff[WIDTH-1:0];
        sc_carry = diff[WIDTH];
        sc_ovf   = (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0110: sc_res = a >> sh;
      4'b0111: sc_res = $signed(a) >>> sh;
      4'b1000: sc_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'b1001: sc_res = {{(WIDTH-1){1'b0}}, a < b};
      default: sc_res = '0;
    endcase
  end
  // acc holds {product high, multiplier} for MUL and {remainder, quotient} for division
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q & {WIDTH{acc_q[0]}}};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign div_t    = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_r    = div_t[WIDTH-1:0] - (b_q & {WIDTH{div_t >= {1'b0, b_q}}});
  assign div_next = {div_r, acc_q[WIDTH-2:0], div_t >= {1'b0, b_q}};
  assign step     = (op_q == OP_MUL) ? mul_next : div_next;
  assign mc_res   = (op_q == OP_REMU) ? step[2*WIDTH-1:WIDTH] : step[WIDTH-1:0];
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    dz_d       = dz_q;
    if (state_q == DONE && out_ready) state_d = IDLE;
    if (accept) begin
      op_d    = op;
      a_d     = a;
      b_d     = b;
      cnt_d   = '0;
      acc_d   = (op == OP_MUL) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
      state_d = is_multi ? EXEC : DONE;
      if (!is_multi) begin
        result_d   = sc_res;
        carry_d    = sc_carry;
        overflow_d = sc_ovf;
        zero_d     = sc_res == '0;
        dz_d       = 1'b0;
      end
    end
    if (state_q == EXEC) begin
      acc_d = step;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == SHW'(WIDTH - 1)) begin
        state_d    = DONE;
        result_d   = mc_res;
        carry_d    = 1'b0;
        overflow_d = (op_q == OP_MUL) & (|step[2*WIDTH-1:WIDTH]);
        zero_d     = mc_res == '0;
        dz_d       = (op_q != OP_MUL) & (b_q == '0);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      dz_q       <= dz_d;
    end
  end
endmodule
